// File: rtl/data_memory_ctrl.sv
// Byte-addressed MEM-stage data memory with valid/ready request/response handshake,
// registered loads, sized accesses with sign/zero extension, and fault reporting.
module data_memory_ctrl #(
    parameter int unsigned DEPTH_BYTES  = 64,
    parameter int unsigned ADDR_W       = 64,
    parameter int unsigned DATA_W       = 64,
    parameter int unsigned INIT_PATTERN = 1,
    localparam int unsigned DBG_W = (DEPTH_BYTES > 8) ? $clog2(DEPTH_BYTES / 8) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              Req_Valid,
    output logic              Req_Ready,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [1:0]        Size,
    input  logic              Unsigned,
    input  logic [ADDR_W-1:0] Memory_Address,
    input  logic [DATA_W-1:0] Write_Data,
    output logic              Resp_Valid,
    input  logic              Resp_Ready,
    output logic [DATA_W-1:0] Read_Data,
    output logic              Fault,
    input  logic [DBG_W-1:0]  Dbg_Index,
    output logic [DATA_W-1:0] Dbg_Data
);

    localparam int unsigned IDX_W = $clog2(DEPTH_BYTES);
    localparam int unsigned AW1   = ADDR_W + 1;

    typedef enum logic {
        S_IDLE,
        S_RESP
    } state_t;

    typedef logic [7:0] mem_t [DEPTH_BYTES];

    function automatic mem_t f_init_mem();
        mem_t m;
        for (int unsigned i = 0; i < DEPTH_BYTES; i++) begin
            m[i] = (INIT_PATTERN != 0) ? 8'(i) : 8'h00;
        end
        return m;
    endfunction

    // Contents come only from the time-zero image; reset deliberately leaves them alone.
    mem_t r_mem = f_init_mem();

    state_t              r_state;
    state_t              w_next;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_fault;

    logic [3:0]          w_size_bytes;
    logic                w_misaligned;
    logic [AW1-1:0]      w_end;
    logic                w_oob;
    logic                w_fault;
    logic [IDX_W-1:0]    w_lo;
    logic                w_req_ready;
    logic                w_accept;
    logic                w_store_en;
    logic [DATA_W-1:0]   w_raw;
    logic [DATA_W-1:0]   w_ext;
    logic [DATA_W-1:0]   w_dbg;

    assign w_size_bytes = 4'd1 << Size;
    assign w_misaligned = (Memory_Address[2:0] & (w_size_bytes[2:0] - 3'd1)) != 3'd0;
    // One extra bit so addresses near the top of the space cannot wrap back into range.
    assign w_end        = {1'b0, Memory_Address} + AW1'(w_size_bytes);
    assign w_oob        = w_end > AW1'(DEPTH_BYTES);
    assign w_fault      = (MemRead == MemWrite) | w_misaligned | w_oob;
    assign w_lo         = Memory_Address[IDX_W-1:0];

    assign w_req_ready  = (r_state == S_IDLE) | Resp_Ready;
    assign w_accept     = Req_Valid & w_req_ready;
    assign w_store_en   = w_accept & ~w_fault & MemWrite;

    always_ff @(posedge clock) begin
        if (w_store_en) begin
            for (int unsigned b = 0; b < 8; b++) begin
                if (b < 32'(w_size_bytes)) begin
                    r_mem[w_lo + IDX_W'(b)] <= Write_Data[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        w_raw = '0;
        for (int unsigned b = 0; b < 8; b++) begin
            w_raw[8*b +: 8] = r_mem[w_lo + IDX_W'(b)];
        end
    end

    always_comb begin
        w_ext = '0;
        case (Size)
            2'd0:    w_ext = Unsigned ? {56'd0, w_raw[7:0]}  : {{56{w_raw[7]}},  w_raw[7:0]};
            2'd1:    w_ext = Unsigned ? {48'd0, w_raw[15:0]} : {{48{w_raw[15]}}, w_raw[15:0]};
            2'd2:    w_ext = Unsigned ? {32'd0, w_raw[31:0]} : {{32{w_raw[31]}}, w_raw[31:0]};
            default: w_ext = w_raw;
        endcase
    end

    always_comb begin
        w_dbg = '0;
        for (int unsigned b = 0; b < 8; b++) begin
            w_dbg[8*b +: 8] = r_mem[IDX_W'({Dbg_Index, 3'(b)})];
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_next = S_RESP;
            end
            S_RESP: begin
                if (w_accept)       w_next = S_RESP;
                else if (Resp_Ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rdata <= '0;
            r_fault <= 1'b0;
        end else if (w_accept) begin
            r_fault <= w_fault;
            r_rdata <= (w_fault | MemWrite) ? '0 : w_ext;
        end
    end

    assign Req_Ready  = w_req_ready;
    assign Resp_Valid = (r_state == S_RESP);
    assign Read_Data  = r_rdata;
    assign Fault      = r_fault;
    assign Dbg_Data   = w_dbg;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Self-checking bench for data_memory_ctrl: directed vector table, handshake corner
// sequences, and randomized traffic against a byte-array reference model.
module tb_data_memory_ctrl;

    localparam int unsigned DEPTH = 64;

    logic        clock = 1'b0;
    logic        reset;
    logic        Req_Valid;
    logic        Req_Ready;
    logic        MemRead;
    logic        MemWrite;
    logic [1:0]  Size;
    logic        Unsigned;
    logic [63:0] Memory_Address;
    logic [63:0] Write_Data;
    logic        Resp_Valid;
    logic        Resp_Ready;
    logic [63:0] Read_Data;
    logic        Fault;
    logic [2:0]  Dbg_Index;
    logic [63:0] Dbg_Data;

    int total = 0;
    int bad   = 0;

    logic [7:0] mm [DEPTH];

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  sz;
        logic        un;
        logic [63:0] addr;
        logic [63:0] wd;
        logic [63:0] exp_data;
        logic        exp_fault;
    } vec_t;

    vec_t vecs[$];

    always #5 clock = ~clock;

    data_memory_ctrl #(
        .DEPTH_BYTES (64),
        .ADDR_W      (64),
        .DATA_W      (64),
        .INIT_PATTERN(1)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .Req_Valid     (Req_Valid),
        .Req_Ready     (Req_Ready),
        .MemRead       (MemRead),
        .MemWrite      (MemWrite),
        .Size          (Size),
        .Unsigned      (Unsigned),
        .Memory_Address(Memory_Address),
        .Write_Data    (Write_Data),
        .Resp_Valid    (Resp_Valid),
        .Resp_Ready    (Resp_Ready),
        .Read_Data     (Read_Data),
        .Fault         (Fault),
        .Dbg_Index     (Dbg_Index),
        .Dbg_Data      (Dbg_Data)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference behaviour: legality by arithmetic, bytes in a plain array.
    task automatic model_do(input logic rd, input logic wr, input logic [1:0] sz,
                            input logic un, input logic [63:0] addr, input logic [63:0] wd,
                            output logic [63:0] data, output logic f);
        int unsigned n;
        int unsigned base;
        logic [63:0] v;
        n    = 1 << sz;
        f    = (rd == wr) || ((addr % 64'(n)) != 0) || (({1'b0, addr} + 65'(n)) > 65'(DEPTH));
        data = '0;
        base = 32'(addr % 64'(DEPTH));
        if (!f && wr) begin
            for (int unsigned i = 0; i < n; i++) mm[base + i] = wd[8*i +: 8];
        end
        if (!f && rd) begin
            v = '0;
            for (int unsigned i = 0; i < n; i++) v[8*i +: 8] = mm[base + i];
            if (!un && n < 8 && v[8*n-1]) v = v | (~64'd0 << (8*n));
            data = v;
        end
    endtask

    function automatic logic [63:0] model_dbg(input logic [2:0] idx);
        logic [63:0] v;
        for (int unsigned i = 0; i < 8; i++) v[8*i +: 8] = mm[8*int'(idx) + i];
        return v;
    endfunction

    task automatic drive(input logic rd, input logic wr, input logic [1:0] sz,
                         input logic un, input logic [63:0] addr, input logic [63:0] wd);
        MemRead        = rd;
        MemWrite       = wr;
        Size           = sz;
        Unsigned       = un;
        Memory_Address = addr;
        Write_Data     = wd;
    endtask

    task automatic add_vec(input logic rd, input logic wr, input logic [1:0] sz,
                           input logic un, input logic [63:0] addr, input logic [63:0] wd,
                           input logic [63:0] ed, input logic ef);
        vec_t v;
        v.rd = rd; v.wr = wr; v.sz = sz; v.un = un; v.addr = addr; v.wd = wd;
        v.exp_data = ed; v.exp_fault = ef;
        vecs.push_back(v);
    endtask

    initial begin
        logic [63:0] md;
        logic        mf;
        logic        pending;
        logic [63:0] exp_d;
        logic        exp_f;
        logic        exp_rdy;
        logic [63:0] a;
        int unsigned n;
        int unsigned k;

        for (int unsigned i = 0; i < DEPTH; i++) mm[i] = 8'(i);

        add_vec(1, 0, 2'd3, 0, 64'd8,  64'd0,          64'h0F0E0D0C0B0A0908, 0);
        add_vec(0, 1, 2'd0, 0, 64'd3,  64'hFF,         64'd0,                0);
        add_vec(1, 0, 2'd0, 0, 64'd3,  64'd0,          64'hFFFFFFFFFFFFFFFF, 0);
        add_vec(1, 0, 2'd0, 1, 64'd3,  64'd0,          64'h00000000000000FF, 0);
        add_vec(0, 1, 2'd2, 0, 64'd16, 64'h80000001,   64'd0,                0);
        add_vec(1, 0, 2'd2, 0, 64'd16, 64'd0,          64'hFFFFFFFF80000001, 0);
        add_vec(1, 0, 2'd3, 0, 64'd16, 64'd0,          64'h1716151480000001, 0);
        add_vec(1, 0, 2'd1, 0, 64'd1,  64'd0,          64'd0,                1);
        add_vec(1, 0, 2'd3, 0, 64'd60, 64'd0,          64'd0,                1);
        add_vec(1, 1, 2'd3, 0, 64'd24, 64'hDEADBEEFDEADBEEF, 64'd0,          1);
        add_vec(1, 0, 2'd3, 0, 64'd24, 64'd0,          64'h1F1E1D1C1B1A1918, 0);
        add_vec(0, 0, 2'd0, 0, 64'd4,  64'd0,          64'd0,                1);
        add_vec(1, 0, 2'd2, 0, 64'd0,  64'd0,          64'hFFFFFFFFFF020100, 0);
        add_vec(1, 0, 2'd2, 1, 64'd0,  64'd0,          64'h00000000FF020100, 0);
        add_vec(0, 1, 2'd1, 0, 64'd40, 64'h1234_8001,  64'd0,                0);
        add_vec(1, 0, 2'd1, 0, 64'd40, 64'd0,          64'hFFFFFFFFFFFF8001, 0);
        add_vec(1, 0, 2'd1, 1, 64'd62, 64'd0,          64'h0000000000003F3E, 0);
        add_vec(1, 0, 2'd3, 0, 64'd56, 64'd0,          64'h3F3E3D3C3B3A3938, 0);
        add_vec(1, 0, 2'd0, 0, 64'h8000000000000000, 64'd0, 64'd0,           1);
        add_vec(1, 0, 2'd3, 0, 64'hFFFFFFFFFFFFFFF8, 64'd0, 64'd0,           1);
        add_vec(0, 1, 2'd0, 0, 64'd64, 64'h77,         64'd0,                1);

        reset = 1'b1; Req_Valid = 1'b0; Resp_Ready = 1'b0; Dbg_Index = 3'd1;
        drive(0, 0, 2'd0, 0, 64'd0, 64'd0);
        #2;
        check("reset_resp_valid", 64'(Resp_Valid), 64'd0);
        check("reset_read_data",  Read_Data,       64'd0);
        check("reset_fault",      64'(Fault),      64'd0);
        check("reset_req_ready",  64'(Req_Ready),  64'd1);
        check("init_dbg_idx1",    Dbg_Data,        64'h0F0E0D0C0B0A0908);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clock);
            drive(vecs[i].rd, vecs[i].wr, vecs[i].sz, vecs[i].un, vecs[i].addr, vecs[i].wd);
            Req_Valid = 1'b1; Resp_Ready = 1'b1;
            #1;
            check($sformatf("vec%0d_req_ready", i), 64'(Req_Ready), 64'd1);
            model_do(vecs[i].rd, vecs[i].wr, vecs[i].sz, vecs[i].un, vecs[i].addr, vecs[i].wd, md, mf);
            @(posedge clock);
            #1;
            Req_Valid = 1'b0;
            check($sformatf("vec%0d_resp_valid", i), 64'(Resp_Valid), 64'd1);
            check($sformatf("vec%0d_data", i),       Read_Data,       vecs[i].exp_data);
            check($sformatf("vec%0d_fault", i),      64'(Fault),      64'(vecs[i].exp_fault));
        end

        // Backpressure: response held while a competing store waits unaccepted.
        @(negedge clock);
        Req_Valid = 1'b0; Resp_Ready = 1'b1;
        @(negedge clock);
        Resp_Ready = 1'b0;
        drive(1, 0, 2'd3, 0, 64'd8, 64'd0);
        Req_Valid = 1'b1;
        #1;
        check("bp_first_ready", 64'(Req_Ready), 64'd1);
        @(posedge clock);
        #1;
        drive(0, 1, 2'd3, 0, 64'd0, 64'hAAAAAAAAAAAAAAAA);
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            check($sformatf("bp%0d_resp_valid", c), 64'(Resp_Valid), 64'd1);
            check($sformatf("bp%0d_data", c),       Read_Data,       64'h0F0E0D0C0B0A0908);
            check($sformatf("bp%0d_fault", c),      64'(Fault),      64'd0);
            check($sformatf("bp%0d_req_ready", c),  64'(Req_Ready),  64'd0);
        end
        for (int c = 0; c < 4; c++) begin
            if (c > 0) @(negedge clock);
            Resp_Ready = 1'b1;
            a = 64'(8 * c);
            drive(1, 0, 2'(c), c[0], a, 64'd0);
            #1;
            check($sformatf("b2b%0d_req_ready", c), 64'(Req_Ready), 64'd1);
            model_do(1, 0, 2'(c), c[0], a, 64'd0, md, mf);
            @(posedge clock);
            #1;
            check($sformatf("b2b%0d_resp_valid", c), 64'(Resp_Valid), 64'd1);
            check($sformatf("b2b%0d_data", c),       Read_Data,       md);
            check($sformatf("b2b%0d_fault", c),      64'(Fault),      64'(mf));
        end
        Req_Valid = 1'b0;
        Dbg_Index = 3'd0;
        @(posedge clock);
        #1;
        check("b2b_drain_valid", 64'(Resp_Valid), 64'd0);
        check("bp_store_blocked", Dbg_Data, 64'h07060504FF020100);

        // Async reset while a load response is pending.
        @(negedge clock);
        drive(0, 1, 2'd3, 0, 64'd32, 64'h1122334455667788);
        Req_Valid = 1'b1; Resp_Ready = 1'b1;
        model_do(0, 1, 2'd3, 0, 64'd32, 64'h1122334455667788, md, mf);
        @(negedge clock);
        drive(1, 0, 2'd3, 0, 64'd32, 64'd0);
        model_do(1, 0, 2'd3, 0, 64'd32, 64'd0, md, mf);
        @(posedge clock);
        #1;
        Req_Valid = 1'b0; Resp_Ready = 1'b0; Dbg_Index = 3'd4;
        check("raw_load_data", Read_Data, 64'h1122334455667788);
        check("raw_load_valid", 64'(Resp_Valid), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_resp_valid", 64'(Resp_Valid), 64'd0);
        check("arst_read_data",  Read_Data,       64'd0);
        check("arst_fault",      64'(Fault),      64'd0);
        check("arst_dbg_store",  Dbg_Data,        64'h1122334455667788);
        @(negedge clock);
        reset = 1'b0;

        // Randomized traffic against the reference model.
        pending = 1'b0; exp_d = '0; exp_f = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clock);
            check("rnd_resp_valid", 64'(Resp_Valid), 64'(pending));
            if (pending) begin
                check("rnd_data",  Read_Data,  exp_d);
                check("rnd_fault", 64'(Fault), 64'(exp_f));
            end
            check("rnd_dbg", Dbg_Data, model_dbg(Dbg_Index));

            Req_Valid = ($urandom_range(0, 9) < 7);
            k = $urandom_range(0, 9);
            if (k < 5)      begin MemRead = 1'b1; MemWrite = 1'b0; end
            else if (k < 9) begin MemRead = 1'b0; MemWrite = 1'b1; end
            else            begin MemRead = 1'($urandom_range(0, 1)); MemWrite = MemRead; end
            Size = 2'($urandom_range(0, 3));
            n = 1 << Size;
            k = $urandom_range(0, 9);
            if (k < 7)      a = 64'($urandom_range(0, DEPTH - 1)) & ~64'(n - 1);
            else if (k < 9) a = 64'($urandom_range(0, DEPTH - 1));
            else            a = {$urandom, $urandom};
            Memory_Address = a;
            Unsigned   = 1'($urandom_range(0, 1));
            Write_Data = {$urandom, $urandom};
            Resp_Ready = ($urandom_range(0, 3) != 0);
            Dbg_Index  = 3'($urandom_range(0, 7));
            #1;
            exp_rdy = !pending || Resp_Ready;
            check("rnd_req_ready", 64'(Req_Ready), 64'(exp_rdy));
            if (Req_Valid && exp_rdy) begin
                model_do(MemRead, MemWrite, Size, Unsigned, Memory_Address, Write_Data, md, mf);
                pending = 1'b1; exp_d = md; exp_f = mf;
            end else if (Resp_Ready) begin
                pending = 1'b0;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
